uart_mmio_bridge: RTL and testbench

UART_MMIO_BRIDGE -- requirements
Module: uart_mmio_bridge

---
 rtl/uart_mmio_bridge.sv | 187 ++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge
//   Memory-mapped front end for a byte UART. Bus writes to TXDATA are queued
//   in a small register FIFO and handed to the UART transmitter one frame at a
//   time. Received bytes are captured into a one-deep holding register. Error
//   conditions are recorded in sticky STATUS bits, which are cleared by
//   writing 1 to them.
//
//   Ports
//     clk, reset        single rising-edge clock, synchronous active-high reset
//     MemWrite/MemRead  bus strobes; side effects happen at the clock edge
//     Address/WriteData 32-bit byte address and write data
//     ReadData          combinational read data (0 for unmapped addresses)
//     Transmit, DataTx  one-cycle start pulse and byte for the UART transmitter
//     DataRx, Rx_flag   received byte and "byte ready" flag from the UART receiver
//     Parity_error      parity status of the received byte
//     clr_rx_flag       one-cycle acknowledge that clears Rx_flag

module uart_mmio_bridge #(
    parameter int Nbit       = 8,
    parameter int baudrate   = 9600,
    parameter int clk_freq   = 50000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWrite,
    input  logic            MemRead,
    input  logic [31:0]     Address,
    input  logic [31:0]     WriteData,
    output logic [31:0]     ReadData,
    output logic            Transmit,
    output logic [Nbit-1:0] DataTx,
    input  logic [Nbit-1:0] DataRx,
    input  logic            Rx_flag,
    input  logic            Parity_error,
    output logic            clr_rx_flag
);

    localparam logic [31:0] ADDR_TXDATA = 32'h1001_0028;
    localparam logic [31:0] ADDR_RXDATA = 32'h1001_002C;
    localparam logic [31:0] ADDR_STATUS = 32'h1001_0030;

    // Clock cycles occupied by one frame: start + data + parity + stop.
    localparam int FRAME_CYC = (clk_freq / baudrate) * (Nbit + 3);
    localparam int CNT_W     = $clog2(FRAME_CYC + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT
    } tx_state_t;

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;

    logic [Nbit-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              tx_full, tx_empty, tx_busy;
    logic              push, pop;

    logic [Nbit-1:0] rx_hold;
    logic            rx_valid, par_err, overrun, tx_ovf;
    logic            wr_tx, rd_rx, wr_st;
    logic            rx_capture, ovr_set, par_set, tovf_set;

    // Upper write-data bits carry no register content.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, WriteData[31:Nbit]};

    assign wr_tx = MemWrite && (Address == ADDR_TXDATA);
    assign rd_rx = MemRead  && (Address == ADDR_RXDATA);
    assign wr_st = MemWrite && (Address == ADDR_STATUS);

    assign tx_full  = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    assign tx_empty = (fifo_cnt == '0);
    assign tx_busy  = (state_q != S_IDLE);

    // Full is judged on the pre-edge count, so a pop in the same cycle does
    // not make room for the write.
    assign push     = wr_tx && !tx_full;
    assign tovf_set = wr_tx && tx_full;

    // A read of RXDATA in the same cycle frees the holding register, so the
    // incoming byte is taken instead of being counted as an overrun.
    assign rx_capture = Rx_flag && (!rx_valid || rd_rx);
    assign ovr_set    = Rx_flag && !rx_capture;
    assign par_set    = rx_capture && Parity_error;

    // TX sequencer: next state
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tx_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop        = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == CNT_W'(FRAME_CYC - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // TX sequencer: state, start pulse and held output byte
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
            Transmit <= 1'b0;
            DataTx   <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
            Transmit <= pop;
            if (pop) DataTx <= fifo_mem[rd_ptr];
        end
    end

    // FIFO storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= WriteData[Nbit-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // RX capture and sticky status; a set in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_hold     <= '0;
            rx_valid    <= 1'b0;
            clr_rx_flag <= 1'b0;
            par_err     <= 1'b0;
            overrun     <= 1'b0;
            tx_ovf      <= 1'b0;
        end else begin
            clr_rx_flag <= Rx_flag;
            if (rx_capture) begin
                rx_hold  <= DataRx;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            par_err <= (par_err & ~(wr_st & WriteData[3])) | par_set;
            overrun <= (overrun & ~(wr_st & WriteData[4])) | ovr_set;
            tx_ovf  <= (tx_ovf  & ~(wr_st & WriteData[6])) | tovf_set;
        end
    end

    always_comb begin
        ReadData = '0;
        if (Address == ADDR_RXDATA) begin
            ReadData = 32'({rx_valid, rx_hold});
        end else if (Address == ADDR_STATUS) begin
            ReadData = {25'd0, tx_ovf, tx_busy, overrun, par_err,
                        rx_valid, tx_empty, tx_full};
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge
//   Directed and randomized stimulus for uart_mmio_bridge, using a short frame
//   time. Expected outputs come from a transaction-level model: a byte queue,
//   the edge at which the transmitter is next free, and the RX/status flags.

module tb_uart_mmio_bridge;

    localparam int NB    = 8;
    localparam int BAUD  = 10;
    localparam int CLKF  = 100;
    localparam int DEPTH = 4;
    localparam int F     = (CLKF / BAUD) * (NB + 3);

    localparam logic [31:0] A_TX = 32'h1001_0028;
    localparam logic [31:0] A_RX = 32'h1001_002C;
    localparam logic [31:0] A_ST = 32'h1001_0030;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWrite, MemRead;
    logic [31:0]   Address, WriteData, ReadData;
    logic          Transmit;
    logic [NB-1:0] DataTx, DataRx;
    logic          Rx_flag, Parity_error, clr_rx_flag;

    uart_mmio_bridge #(
        .Nbit(NB), .baudrate(BAUD), .clk_freq(CLKF), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .Transmit(Transmit), .DataTx(DataTx), .DataRx(DataRx),
        .Rx_flag(Rx_flag), .Parity_error(Parity_error),
        .clr_rx_flag(clr_rx_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    int            n = 0;
    logic [7:0]    mq[$];
    int            free_at, pop_edge;
    logic [7:0]    m_dtx, m_hold;
    logic          m_txp, m_clr, m_valid, m_par, m_ovr, m_tovf;

    // observed Transmit pulses (edge index, byte)
    int            pn[$];
    logic [7:0]    pb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic busy;
        busy = (n < free_at);
        if (a == A_RX) return {23'd0, m_valid, m_hold};
        if (a == A_ST) return {25'd0, m_tovf, busy, m_ovr, m_par, m_valid,
                               (mq.size() == 0), (mq.size() == DEPTH)};
        return 32'd0;
    endfunction

    task automatic model_edge();
        int   pre;
        logic wr_tx, rd_rx, wr_st, cap;
        n++;
        if (reset) begin
            mq.delete();
            free_at = n; pop_edge = -1;
            m_dtx = 0; m_txp = 0; m_clr = 0; m_hold = 0; m_valid = 0;
            m_par = 0; m_ovr = 0; m_tovf = 0;
            return;
        end
        wr_tx = MemWrite && (Address == A_TX);
        rd_rx = MemRead  && (Address == A_RX);
        wr_st = MemWrite && (Address == A_ST);
        pre   = mq.size();
        m_txp = 0;
        if (pop_edge == n) begin
            m_dtx = mq.pop_front();
            m_txp = 1;
            pop_edge = -1;
        end else if (n > free_at && pre > 0) begin
            pop_edge = n + 1;
            free_at  = n + 1 + F;
        end
        if (wr_st && WriteData[6]) m_tovf = 0;
        if (wr_st && WriteData[4]) m_ovr = 0;
        if (wr_st && WriteData[3]) m_par = 0;
        if (wr_tx) begin
            if (pre == DEPTH) m_tovf = 1;
            else mq.push_back(WriteData[7:0]);
        end
        cap   = Rx_flag && (!m_valid || rd_rx);
        m_clr = Rx_flag;
        if (cap) begin
            m_hold  = DataRx;
            m_valid = 1;
            if (Parity_error) m_par = 1;
        end else begin
            if (Rx_flag) m_ovr = 1;
            if (rd_rx) m_valid = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("transmit", Transmit, m_txp);
        chk("datatx", DataTx, m_dtx);
        chk("clr_rx_flag", clr_rx_flag, m_clr);
        chk("readdata", ReadData, model_rd(Address));
        if (Transmit === 1'b1) begin
            pn.push_back(n);
            pb.push_back(DataTx);
        end
    endtask

    task automatic bus_idle();
        MemWrite = 0; MemRead = 0; Rx_flag = 0; Parity_error = 0;
    endtask

    initial begin
        int w, busy, c;
        reset = 1; MemWrite = 0; MemRead = 0; Address = 0; WriteData = 0;
        DataRx = 0; Rx_flag = 0; Parity_error = 0;
        step(); step();
        reset = 0; Address = A_ST; #1;
        chk("rst_status", ReadData, 32'h2);
        chk("rst_transmit", Transmit, 0);
        chk("rst_datatx", DataTx, 0);
        chk("rst_clr", clr_rx_flag, 0);
        step();

        // single byte
        pn.delete(); pb.delete();
        Address = A_TX; MemWrite = 1; WriteData = 32'h41;
        step(); w = n;
        MemWrite = 0; Address = A_ST; busy = 0;
        repeat (F + 20) begin
            step();
            if (ReadData[5]) busy++;
        end
        chk("single_pulses", pn.size(), 1);
        if (pn.size() >= 1) begin
            chk("single_delay", pn[0] - w, 2);
            chk("single_byte", pb[0], 8'h41);
        end
        chk("single_busy", busy, F + 1);

        // six back-to-back writes, last one dropped
        pn.delete(); pb.delete();
        Address = A_TX; MemWrite = 1;
        for (int i = 0; i < 6; i++) begin
            WriteData = 32'h11 * (i + 1);
            step();
            if (i == 0) w = n;
        end
        MemWrite = 0; Address = A_ST; #1;
        chk("burst_txovf", ReadData[6], 1);
        repeat (5 * (F + 2) + 10) step();
        chk("burst_pulses", pn.size(), 5);
        if (pn.size() >= 1) chk("burst_first_delay", pn[0] - w, 2);
        for (int i = 0; i < pn.size(); i++) begin
            chk("burst_byte", pb[i], 8'h11 * (i + 1));
            if (i > 0) chk("burst_spacing", pn[i] - pn[i-1], F + 2);
        end
        MemWrite = 1; WriteData = 32'h40; step(); MemWrite = 0;
        chk("txovf_clear", ReadData[6], 0);

        // single receive, two reads
        c = 0;
        Rx_flag = 1; DataRx = 8'hA5; Parity_error = 0; step(); c += clr_rx_flag;
        Rx_flag = 0; step(); c += clr_rx_flag;
        step(); c += clr_rx_flag;
        chk("rx_clr_count", c, 1);
        Address = A_RX; #1;
        chk("rx_read1", ReadData, 32'h1A5);
        MemRead = 1; step(); MemRead = 0;
        chk("rx_read2", ReadData, 32'h0A5);

        // overrun
        Rx_flag = 1; DataRx = 8'h01; step();
        Rx_flag = 0; step();
        Rx_flag = 1; DataRx = 8'h02; step();
        Rx_flag = 0; step();
        Address = A_RX; #1;
        chk("ovr_rxdata", ReadData, 32'h101);
        Address = A_ST; #1;
        chk("ovr_set", ReadData[4], 1);
        MemWrite = 1; WriteData = 32'h10; step(); MemWrite = 0;
        chk("ovr_clear", ReadData[4], 0);
        Address = A_RX; MemRead = 1; step(); MemRead = 0;

        // parity error, clear racing a new error
        Rx_flag = 1; DataRx = 8'h3C; Parity_error = 1; step();
        bus_idle(); step();
        Address = A_ST; #1;
        chk("par_set", ReadData[3], 1);
        Address = A_RX; MemRead = 1; step(); MemRead = 0;
        Address = A_ST; MemWrite = 1; WriteData = 32'h08;
        Rx_flag = 1; DataRx = 8'h5A; Parity_error = 1; step();
        bus_idle();
        chk("par_set_wins", ReadData[3], 1);
        MemWrite = 1; WriteData = 32'h08; step(); MemWrite = 0;
        chk("par_clear", ReadData[3], 0);

        // read and capture in the same cycle
        Address = A_RX; MemRead = 1; Rx_flag = 1; DataRx = 8'hC3; step();
        bus_idle(); #1;
        chk("rdcap_rxdata", ReadData, 32'h1C3);
        Address = A_ST; #1;
        chk("rdcap_no_ovr", ReadData[4], 0);
        Address = A_RX; MemRead = 1; step(); MemRead = 0;

        // reset during a frame with two bytes queued
        pn.delete(); pb.delete();
        Address = A_TX; MemWrite = 1;
        for (int i = 0; i < 3; i++) begin
            WriteData = 32'h71 + i;
            step();
        end
        MemWrite = 0;
        repeat (8) step();
        chk("midrst_started", pn.size(), 1);
        reset = 1; MemWrite = 1; Address = A_TX; WriteData = 32'h99; step();
        reset = 0; MemWrite = 0; Address = A_ST; #1;
        chk("midrst_status", ReadData, 32'h2);
        pn.delete();
        repeat (F + 20) step();
        chk("midrst_no_pulse", pn.size(), 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset        = ($urandom_range(0, 149) == 0);
            MemWrite     = ($urandom_range(0, 2) == 0);
            MemRead      = ($urandom_range(0, 2) == 0);
            WriteData    = $urandom;
            Rx_flag      = ($urandom_range(0, 7) == 0);
            DataRx       = 8'($urandom);
            Parity_error = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0, 1:    Address = A_TX;
                2:       Address = A_RX;
                3:       Address = A_ST;
                default: Address = 32'h1001_0034;
            endcase
            step();
        end
        reset = 0; bus_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
